// File: rtl/unary_stream_matmul.sv
// ============================================================================
// unary_stream_matmul : C = A x B with thermometer-coded A gating binary B.
// Optional UNARY_EARLY_TERM_EN ends RUN at the largest A element. Rev 1.0
// ============================================================================
`default_nettype none

module unary_stream_matmul #(
  parameter int A_W   = 4,
  parameter int B_W   = 4,
  parameter int M     = 2,
  parameter int K     = 2,
  parameter int N     = 2,
  parameter int OUT_W = A_W + B_W + $clog2(K)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [M*K*A_W-1:0]     a_flat,
  input  logic [K*N*B_W-1:0]     b_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [M*N*OUT_W-1:0]   c_flat,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [A_W-1:0] T_LAST = A_W'((2 ** A_W) - 2);

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [M*K*A_W-1:0]    a_reg;
  logic [K*N*B_W-1:0]    b_reg;
  logic [A_W-1:0]        t;
  logic                  run_last;
  logic                  accept;
  logic [OUT_W-1:0]      sum [M][N];

  assign accept = in_valid && in_ready;

`ifdef UNARY_EARLY_TERM_EN
  logic [A_W-1:0] amax;
  logic [A_W-1:0] amax_in;

  always_comb begin
    amax_in = '0;
    for (int e = 0; e < M*K; e++) begin
      if (a_flat[e*A_W +: A_W] > amax_in) amax_in = a_flat[e*A_W +: A_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   amax <= '0;
    else if (accept) amax <= amax_in;
  end

  // amax==0 still spends one RUN cycle, in which every unary bit is zero.
  assign run_last = (amax == '0) || (t == amax - A_W'(1));
`else
  assign run_last = (t == T_LAST);
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept)    state_next = S_RUN;
      S_RUN:   if (run_last)  state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == S_IDLE);
    busy      = (state != S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Per-output sum of B terms gated by the unary bit (t < A[i][k])
  always_comb begin
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        sum[i][j] = '0;
        for (int k = 0; k < K; k++) begin
          if (t < a_reg[(i*K+k)*A_W +: A_W])
            sum[i][j] = sum[i][j] + OUT_W'(b_reg[(k*N+j)*B_W +: B_W]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      t      <= '0;
      c_flat <= '0;
    end else if (state == S_IDLE) begin
      if (accept) begin
        a_reg  <= a_flat;
        b_reg  <= b_flat;
        t      <= '0;
        c_flat <= '0;
      end
    end else if (state == S_RUN) begin
      t <= t + A_W'(1);
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < N; j++) begin
          c_flat[(i*N+j)*OUT_W +: OUT_W] <= c_flat[(i*N+j)*OUT_W +: OUT_W] + sum[i][j];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_unary_stream_matmul.sv
// Testbench for unary_stream_matmul: directed and random transactions vs a dot-product model.
`default_nettype none

module tb_unary_stream_matmul;

  localparam int A_W   = 4;
  localparam int B_W   = 4;
  localparam int M     = 2;
  localparam int K     = 2;
  localparam int N     = 2;
  localparam int OUT_W = A_W + B_W + $clog2(K);
  localparam int AF    = M*K*A_W;
  localparam int BF    = K*N*B_W;
  localparam int CF    = M*N*OUT_W;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [AF-1:0] a_flat = '0;
  logic [BF-1:0] b_flat = '0;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [CF-1:0] c_flat;

  int total = 0;
  int bad   = 0;

  unary_stream_matmul #(
    .A_W(A_W), .B_W(B_W), .M(M), .K(K), .N(N), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_flat(a_flat), .b_flat(b_flat), .out_valid(out_valid), .out_ready(out_ready),
    .c_flat(c_flat), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [CF-1:0] model_c(input logic [AF-1:0] a, input logic [BF-1:0] b);
    logic [CF-1:0] c;
    int s;
    c = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < K; k++)
          s += int'(a[(i*K+k)*A_W +: A_W]) * int'(b[(k*N+j)*B_W +: B_W]);
        c[(i*N+j)*OUT_W +: OUT_W] = OUT_W'(s);
      end
    end
    return c;
  endfunction

  function automatic int model_lat(input logic [AF-1:0] a);
`ifdef UNARY_EARLY_TERM_EN
    int mx;
    mx = 0;
    for (int e = 0; e < M*K; e++)
      if (int'(a[e*A_W +: A_W]) > mx) mx = int'(a[e*A_W +: A_W]);
    return (mx < 1) ? 1 : mx;
`else
    return (2 ** A_W) - 1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands while idle; returns just after the accepting edge.
  task automatic start(input logic [AF-1:0] a, input logic [BF-1:0] b, input string tag);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, ":ready"}, 64'(in_ready), 64'd1);
    a_flat   = a;
    b_flat   = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_flat   = AF'($urandom);
    b_flat   = BF'($urandom);
    chk({tag, ":busy"}, {62'd0, busy, in_ready}, 64'd2);
  endtask

  task automatic wait_result(input logic [AF-1:0] a, input string tag);
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 100);
    chk({tag, ":latency"}, 64'(cyc), 64'(model_lat(a)));
  endtask

  task automatic drain(input logic [CF-1:0] exp, input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ":idle"}, {61'd0, out_valid, in_ready, busy}, 64'd2);
    chk({tag, ":c_held"}, 64'(c_flat), 64'(exp));
  endtask

  task automatic txn(input logic [AF-1:0] a, input logic [BF-1:0] b, input string tag);
    start(a, b, tag);
    wait_result(a, tag);
    chk({tag, ":c"}, 64'(c_flat), 64'(model_c(a, b)));
    drain(model_c(a, b), tag);
  endtask

  initial begin
    logic [AF-1:0] a;
    logic [BF-1:0] b;
    logic [CF-1:0] exp_c;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {61'd0, in_ready, out_valid, busy}, 64'd4);
    chk("reset_c", 64'(c_flat), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // A=[[1,2],[3,4]] B=[[5,6],[7,8]] -> C=[[19,22],[43,50]]
    a = {4'd4, 4'd3, 4'd2, 4'd1};
    b = {4'd8, 4'd7, 4'd6, 4'd5};
    start(a, b, "example");
    wait_result(a, "example");
    chk("example:c", 64'(c_flat), 64'({9'd50, 9'd43, 9'd22, 9'd19}));
    drain({9'd50, 9'd43, 9'd22, 9'd19}, "example");

    a = '1;
    b = '1;
    start(a, b, "saturate");
    wait_result(a, "saturate");
    chk("saturate:c", 64'(c_flat), 64'({9'd450, 9'd450, 9'd450, 9'd450}));
    drain({9'd450, 9'd450, 9'd450, 9'd450}, "saturate");

    txn('0, BF'($urandom), "zero");

    // Backpressure: hold result 10 cycles while an in_valid pulse is offered.
    a = {4'd9, 4'd0, 4'd13, 4'd6};
    b = {4'd2, 4'd15, 4'd11, 4'd7};
    exp_c = model_c(a, b);
    start(a, b, "bp");
    wait_result(a, "bp");
    for (int cy = 0; cy < 10; cy++) begin
      if (cy == 3) begin
        a_flat   = {4'd1, 4'd1, 4'd1, 4'd1};
        b_flat   = {4'd1, 4'd1, 4'd1, 4'd1};
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("bp:c_stable", 64'(c_flat), 64'(exp_c));
      chk("bp:hold", {62'd0, out_valid, in_ready}, 64'd2);
    end
    in_valid = 1'b0;
    drain(exp_c, "bp");
    txn({4'd3, 4'd12, 4'd5, 4'd10}, {4'd14, 4'd1, 4'd9, 4'd4}, "after_bp");

    // Reset mid-RUN at t=7
    start(16'hF9F3, 16'h5A3C, "rst_run");
    repeat (7) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_run:ctrl", {61'd0, in_ready, out_valid, busy}, 64'd4);
    chk("rst_run:c", 64'(c_flat), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    txn({4'd7, 4'd2, 4'd11, 4'd5}, {4'd6, 4'd13, 4'd3, 4'd9}, "after_rst");

    for (int r = 0; r < 6; r++) begin
      a = AF'($urandom);
      b = BF'($urandom);
      txn(a, b, $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
